// File: rtl/fle_frac_k_if.sv
// Bus bundle for one fracturable logic element: config/scan controls, LUT
// inputs, carry and serial chains, and the two logic outputs.
interface fle_frac_k_if #(
  parameter int K = 4
);
  logic         config_enable;
  logic         Test_en;
  logic [K-1:0] fle_in;
  logic         fle_sc_in;
  logic         fle_cin;
  logic         ccff_head;
  logic [1:0]   fle_out;
  logic         fle_sc_out;
  logic         fle_cout;
  logic         ccff_tail;

  modport master (
    output config_enable, Test_en, fle_in, fle_sc_in, fle_cin, ccff_head,
    input  fle_out, fle_sc_out, fle_cout, ccff_tail
  );

  modport slave (
    input  config_enable, Test_en, fle_in, fle_sc_in, fle_cin, ccff_head,
    output fle_out, fle_sc_out, fle_cout, ccff_tail
  );
endinterface

// File: rtl/fle_frac_k.sv
// Fracturable K-input logic element: splittable LUT, optional full adder,
// two bypassable output flops with scan, and a serial configuration chain.
module fle_frac_k #(
  parameter int K = 4
) (
  input  logic         fle_clk,
  input  logic         fle_reset,
  fle_frac_k_if.slave  bus
);
  localparam int N       = 2**K;
  localparam int H       = N / 2;
  localparam int CFG_LEN = N + 4;

  logic [CFG_LEN-1:0] cfg_reg;
  logic [1:0]         ff_reg;

  logic [N-1:0] truth_tbl;
  logic [H-1:0] tbl_lo;
  logic [H-1:0] tbl_hi;
  logic         frac;
  logic         arith;
  logic [1:0]   byp;
  logic         split;
  logic [K-2:0] low_idx;
  logic         o0;
  logic         o1;
  logic         sum;
  logic [1:0]   d_vec;
  logic [1:0]   out_vec;

  always_ff @(posedge fle_clk or negedge fle_reset) begin
    if (!fle_reset) begin
      cfg_reg <= '0;
    end else if (bus.config_enable) begin
      cfg_reg <= {cfg_reg[CFG_LEN-2:0], bus.ccff_head};
    end
  end

  assign truth_tbl = cfg_reg[N-1:0];
  assign tbl_lo    = truth_tbl[H-1:0];
  assign tbl_hi    = truth_tbl[N-1:H];
  assign frac      = cfg_reg[N];
  assign arith     = cfg_reg[N+1];
  assign byp       = cfg_reg[N+3:N+2];

  // Arithmetic mode needs two independent operands, so it always fractures.
  assign split   = frac | arith;
  assign low_idx = bus.fle_in[K-2:0];
  assign o0      = split ? tbl_lo[low_idx] : truth_tbl[bus.fle_in];
  assign o1      = split ? tbl_hi[low_idx] : truth_tbl[bus.fle_in];

  assign sum          = o0 ^ o1 ^ bus.fle_cin;
  assign bus.fle_cout = arith & ((o0 & o1) | (o0 & bus.fle_cin) | (o1 & bus.fle_cin));
  assign d_vec        = {o1, arith ? sum : o0};

  // Configuration shifting outranks scan; the flops freeze while programming.
  always_ff @(posedge fle_clk or negedge fle_reset) begin
    if (!fle_reset) begin
      ff_reg <= 2'b00;
    end else if (bus.config_enable) begin
      ff_reg <= ff_reg;
    end else if (bus.Test_en) begin
      ff_reg <= {ff_reg[0], bus.fle_sc_in};
    end else begin
      ff_reg <= d_vec;
    end
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_out
      assign out_vec[gi] = byp[gi] ? d_vec[gi] : ff_reg[gi];
    end
  endgenerate

  assign bus.fle_out    = out_vec;
  assign bus.fle_sc_out = ff_reg[1];
  assign bus.ccff_tail  = cfg_reg[CFG_LEN-1];
endmodule

// File: doc/fle_frac_k.md
Name: fle_frac_k

Overview:
- Parametrised fracturable logic element, the next generation of the fixed 4-input fle.
- Contains:
  - a K-input LUT that can be split into two (K-1)-input LUTs;
  - an optional 1-bit full adder using the carry chain;
  - two output flip-flops, each with a bypass, and a scan chain through both;
  - an on-block configuration shift chain clocked by the same clock.
- Sits inside the CLB. Instances chain through ccff, sc and cin/cout.

Parameters:
- K, 4, LUT input count. Legal range 3..6.
- CFG_LEN, 2**K+4, configuration chain length. Derived; not overridable.

Ports:
- fle_clk  input  1  sole clock, rising edge.
- fle_reset  input  1  asynchronous, active-low reset.
- config_enable  input  1  1 = configuration shift mode.
- Test_en  input  1  1 = scan mode. Used only when config_enable=0.
- fle_in  input  K  LUT inputs. Bit 0 is the LSB of the LUT index.
- fle_sc_in  input  1  scan-in.
- fle_cin  input  1  carry-in.
- ccff_head  input  1  configuration serial in.
- fle_out  output  2  logic outputs.
- fle_sc_out  output  1  scan-out.
- fle_cout  output  1  carry-out.
- ccff_tail  output  1  configuration serial out.

Behaviour:

Reset:
- fle_reset=0 asynchronously clears cfg[CFG_LEN-1:0], ff0 and ff1.
- Resulting outputs: fle_out=2'b00, fle_sc_out=0, fle_cout=0, ccff_tail=0.
- Reset asserted mid-shift or mid-scan loses all progress. No partial state survives.

Configuration chain:
- On each edge with config_enable=1: cfg[0]<=ccff_head and cfg[i]<=cfg[i-1].
- ccff_tail=cfg[CFG_LEN-1] (registered).
- After CFG_LEN shifts, the first bit shifted in sits in cfg[CFG_LEN-1].
- Bit map:
  - cfg[2**K-1:0] = truth table.
  - cfg[2**K] = frac.
  - cfg[2**K+1] = arith.
  - cfg[2**K+2] = byp0.
  - cfg[2**K+3] = byp1.
- When config_enable=0, cfg holds.

LUT (combinational):
- frac=0: o0=o1=cfg[fle_in].
- frac=1: idx=fle_in[K-2:0]; o0=cfg[idx]; o1=cfg[2**(K-1)+idx]. fle_in[K-1] is ignored.
- arith=1 forces fractured indexing regardless of frac.

Adder:
- arith=1:
  - sum = o0^o1^fle_cin.
  - fle_cout = (o0&o1)|(o0&fle_cin)|(o1&fle_cin).
- arith=0: fle_cout=0.
- Data into the flip-flops: d0 = arith ? sum : o0; d1 = o1.

Flip-flops, priority per edge:
1. reset.
2. config_enable=1: ff0 and ff1 hold.
3. Test_en=1: ff0<=fle_sc_in, ff1<=ff0.
4. Otherwise: ff0<=d0, ff1<=d1.

Outputs:
- fle_out[i] = byp_i ? d_i : ff_i.
- Latency: 0 cycles when bypassed, 1 cycle when registered.
- fle_sc_out = ff1 at all times.

Boundary conditions:
- config_enable and Test_en both high: config shift only; flip-flops hold.
- The carry path is combinational cin->cout with no register. Chain length is the CLB's timing concern.
- Outputs remain valid during configuration and reflect partially shifted cfg. The CLB masks them during programming.

Test Plan:
1. Reset during a config shift after 7 bits, then release → fle_out=00, ccff_tail=0, fle_sc_out=0. A further 20 zero shifts keep ccff_tail=0.
2. K=4. Load cfg with only truth-table bit 15 set, frac=0, byp0=1, byp1=0.
   - fle_in=4'hF → fle_out[0]=1 in the same cycle; fle_out[1]=1 after one edge.
   - fle_in=4'hE → fle_out[0]=0.
3. frac=1. Lower table = XOR3 (8'h96), upper table = AND3 (8'h80), byp=00.
   - fle_in=4'b0111 → one edge later fle_out=2'b11.
   - fle_in=4'b1011 → one edge later fle_out=2'b00. fle_in[3] is ignored.
4. arith=1. Lower table = fle_in[0] (8'hAA), upper table = fle_in[1] (8'hCC).
   - fle_in[1:0]=11, cin=1 → sum=1, fle_cout=1.
   - fle_in[1:0]=01, cin=0 → sum=1, fle_cout=0.
   - fle_in[1:0]=00, cin=1 → sum=1, fle_cout=0.
5. Scan: Test_en=1, fle_sc_in driven 1 then 0 → fle_sc_out is 1 after the 2nd edge and 0 after the 3rd. Functional inputs are ignored throughout.
6. Shift pattern P (20 bits), then shift 20 more bits with config_enable=1 → ccff_tail reproduces P first-bit-first. ff0 and ff1 are unchanged during the shift, even with Test_en=1.
